// File: rtl/keypad_pkg.sv
// keypad_pkg: scan-state type and active-low row-pattern decode shared by the keypad scanner and decoder
package keypad_pkg;
  typedef enum logic [2:0] {SCAN, PRESS_DB, CONFIRM, HOLD, REL_DB} scan_state_t;
  typedef struct packed {
    logic       one;
    logic [2:0] idx;
  } low_idx_t;
  // rows_n is padded to 8 bits with 1s; one is set only when exactly one row is low
  function automatic low_idx_t onehot_low_idx(input logic [7:0] rows_n);
    low_idx_t   r;
    logic [3:0] n;
    r = '0;
    n = '0;
    for (int i = 0; i < 8; i++)
      if (!rows_n[i]) begin
        n = n + 4'd1;
        r.idx = 3'(i);
      end
    r.one = n == 4'd1;
    return r;
  endfunction
endpackage

// File: rtl/keypad_scan_ctrl_debounce.sv
// debounce_timer: clearable saturating window counter; done marks the terminal count while enabled
module debounce_timer #(
  parameter int DEBOUNCE = 480000
) (
  input  logic int_osc,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic done
);
  localparam int W = $clog2(DEBOUNCE);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge int_osc or posedge reset)
    if (reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && cnt != LAST) cnt <= cnt + 1'b1;
  assign done = en && cnt == LAST;
endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: column-scanning matrix keypad controller with press/release debounce
module keypad_scan_ctrl #(
  parameter int NROWS    = 4,
  parameter int NCOLS    = 4,
  parameter int DWELL    = 4,
  parameter int SYNC_LAT = 2,
  parameter int DEBOUNCE = 480000
) (
  input  logic                     int_osc,
  input  logic                     reset,
  input  logic [NROWS-1:0]         rows_sync,
  output logic [NCOLS-1:0]         cols,
  output logic                     key_valid,
  output logic [$clog2(NROWS)-1:0] key_row,
  output logic [$clog2(NCOLS)-1:0] key_col,
  output logic                     key_held,
  output logic                     multi_err
);
  import keypad_pkg::*;
  localparam int RW = $clog2(NROWS);
  localparam int CW = $clog2(NCOLS);
  localparam int DW = $clog2(DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [DW-1:0] QUAL_MIN   = DW'(SYNC_LAT);
  localparam logic [CW-1:0] COL_LAST   = CW'(NCOLS - 1);
  scan_state_t      state, nxt;
  logic [CW-1:0]    ptr, ptr_nxt, col_adv;
  logic [DW-1:0]    dwell;
  logic [NROWS-1:0] rows_lat;
  logic [7:0]       rows_pad;
  low_idx_t         lo;
  logic             any_low, match, qual, hit, multi, done, clr, en;
  always_comb begin
    rows_pad = '1;
    rows_pad[NROWS-1:0] = rows_sync;
  end
  assign lo      = onehot_low_idx(rows_pad);
  assign any_low = ~&rows_sync;
  assign match   = rows_sync == rows_lat;
  // early dwell samples still reflect the previous column through the synchroniser
  assign qual    = state == SCAN && dwell >= QUAL_MIN && any_low;
  assign col_adv = ptr == COL_LAST ? '0 : ptr + 1'b1;
  assign hit     = state == CONFIRM && lo.one && match;
  assign multi   = state == CONFIRM && any_low && !lo.one;
  always_ff @(posedge int_osc or posedge reset)
    if (reset) state <= SCAN;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      SCAN:     nxt = qual ? PRESS_DB : SCAN;
      PRESS_DB: nxt = !any_low ? SCAN : done ? CONFIRM : PRESS_DB;
      CONFIRM:  nxt = !any_low || (lo.one && !match) ? SCAN : HOLD;
      HOLD:     nxt = any_low ? HOLD : REL_DB;
      REL_DB:   nxt = any_low ? HOLD : done ? SCAN : REL_DB;
      default:  nxt = SCAN;
    endcase
  end
  always_comb begin
    key_held = state == HOLD || state == REL_DB;
    en       = state == PRESS_DB || state == REL_DB;
    clr      = nxt != state;
    ptr_nxt  = (state == SCAN && !qual && dwell == DWELL_LAST) || (state == REL_DB && nxt == SCAN) ? col_adv : ptr;
  end
  debounce_timer #(.DEBOUNCE(DEBOUNCE)) u_timer (
    .int_osc(int_osc),
    .reset  (reset),
    .clr    (clr),
    .en     (en),
    .done   (done)
  );
  always_ff @(posedge int_osc or posedge reset)
    if (reset) begin
      ptr       <= '0;
      cols      <= ~NCOLS'(1);
      dwell     <= '0;
      rows_lat  <= '1;
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      key_row   <= '0;
      key_col   <= '0;
    end else begin
      ptr       <= ptr_nxt;
      cols      <= ~(NCOLS'(1) << ptr_nxt);
      dwell     <= state == SCAN && nxt == SCAN && dwell != DWELL_LAST ? dwell + 1'b1 : '0;
      key_valid <= hit;
      multi_err <= multi;
      if (qual) rows_lat <= rows_sync;
      if (hit) begin
        key_row <= RW'(lo.idx);
        key_col <= ptr;
      end
    end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: scoreboard bench driving a 4x4 and a 2x8 scanner through a keypad plus synchroniser model
module tb_keypad_scan_ctrl;
  localparam int DB  = 8;
  localparam int LAT = 2 + DB + 2;
  typedef struct { bit err; int row; int col; int cyc; } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  ev_t q_a[$];
  ev_t q_b[$];
  ev_t ea, eb;
  logic [3:0] press_a [4];
  logic [7:0] press_b [2];
  logic [3:0] raw_a, pa1, rows_a, cols_a;
  logic [1:0] raw_b, pb1, rows_b;
  logic [7:0] cols_b;
  logic kv_a, held_a, me_a, kv_b, held_b, me_b;
  logic [1:0] row_a, col_a;
  logic row_b;
  logic [2:0] col_b;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  keypad_scan_ctrl #(.NROWS(4), .NCOLS(4), .DWELL(4), .SYNC_LAT(2), .DEBOUNCE(DB)) u_a (
    .int_osc(clk), .reset(rst), .rows_sync(rows_a), .cols(cols_a), .key_valid(kv_a),
    .key_row(row_a), .key_col(col_a), .key_held(held_a), .multi_err(me_a));
  keypad_scan_ctrl #(.NROWS(2), .NCOLS(8), .DWELL(4), .SYNC_LAT(2), .DEBOUNCE(DB)) u_b (
    .int_osc(clk), .reset(rst), .rows_sync(rows_b), .cols(cols_b), .key_valid(kv_b),
    .key_row(row_b), .key_col(col_b), .key_held(held_b), .multi_err(me_b));

  // keypad matrix followed by a two-stage row synchroniser
  always_comb begin
    for (int r = 0; r < 4; r++) raw_a[r] = ~|(press_a[r] & ~cols_a);
    for (int r = 0; r < 2; r++) raw_b[r] = ~|(press_b[r] & ~cols_b);
  end
  always @(posedge clk or posedge rst)
    if (rst) begin
      pa1 <= '1; rows_a <= '1; pb1 <= '1; rows_b <= '1;
    end else begin
      pa1 <= raw_a; rows_a <= pa1; pb1 <= raw_b; rows_b <= pb1;
    end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_col(input bit b, input logic [7:0] t, output int c0);
    logic [7:0] cur, prev;
    prev = b ? cols_b : {4'hf, cols_a};
    cur = prev;
    c0 = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cur = b ? cols_b : {4'hf, cols_a};
      if (cur == t && prev != t) begin
        c0 = cyc;
        return;
      end
      prev = cur;
    end
    chk("wait_col_timeout", cur, t);
  endtask

  always @(negedge clk)
    if (!rst && (kv_a || me_a)) begin
      if (q_a.size() == 0) chk("a_unexpected_pulse", {kv_a, me_a}, 0);
      else begin
        ea = q_a.pop_front();
        chk("a_multi_err", me_a, ea.err);
        chk("a_key_valid", kv_a, !ea.err);
        chk("a_key_row", row_a, ea.row);
        chk("a_key_col", col_a, ea.col);
        chk("a_latency", cyc, ea.cyc);
      end
    end

  always @(negedge clk)
    if (!rst && (kv_b || me_b)) begin
      if (q_b.size() == 0) chk("b_unexpected_pulse", {kv_b, me_b}, 0);
      else begin
        eb = q_b.pop_front();
        chk("b_multi_err", me_b, eb.err);
        chk("b_key_valid", kv_b, !eb.err);
        chk("b_key_row", row_b, eb.row);
        chk("b_key_col", col_b, eb.col);
        chk("b_latency", cyc, eb.cyc);
      end
    end

  initial begin
    int c0;
    logic [3:0] xa;
    logic [7:0] xb;
    for (int r = 0; r < 4; r++) press_a[r] = '0;
    for (int r = 0; r < 2; r++) press_b[r] = '0;
    tick(3);
    chk("rst_cols_a", cols_a, 4'b1110);
    chk("rst_cols_b", cols_b, 8'hfe);
    chk("rst_flags_a", {kv_a, me_a, held_a}, 0);
    chk("rst_idx_a", {row_a, col_a}, 0);
    chk("rst_flags_b", {kv_b, me_b, held_b}, 0);
    rst = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (i > 0) @(negedge clk);
      xa = ~(4'b1 << ((i / 4) % 4));
      xb = ~(8'b1 << ((i / 4) % 8));
      chk("idle_cols_a", cols_a, xa);
      chk("idle_cols_b", cols_b, xb);
    end
    // clean press of row 2 on column 1
    wait_col(0, 8'hfd, c0);
    press_a[2][1] = 1'b1;
    q_a.push_back(ev_t'{1'b0, 2, 1, c0 + LAT});
    tick(14);
    chk("press_held_a", held_a, 1);
    chk("press_seen_a", q_a.size(), 0);
    press_a[2][1] = 1'b0;
    tick(10);
    chk("rel_held_a", held_a, 1);
    tick(2);
    chk("rel_done_held_a", held_a, 0);
    chk("rel_next_col_a", cols_a, 4'b1011);
    // 3-cycle glitch on column 3 freezes then resumes that column
    wait_col(0, 8'hf7, c0);
    press_a[1][3] = 1'b1;
    tick(3);
    press_a[1][3] = 1'b0;
    tick(1);
    chk("bounce_held_a", held_a, 0);
    tick(2);
    chk("bounce_freeze_a", cols_a, 4'b0111);
    tick(3);
    chk("bounce_resume_a", cols_a, 4'b0111);
    tick(1);
    chk("bounce_wrap_a", cols_a, 4'b1110);
    // rows 0 and 3 together on column 2
    wait_col(0, 8'hfb, c0);
    press_a[0][2] = 1'b1;
    press_a[3][2] = 1'b1;
    q_a.push_back(ev_t'{1'b1, 2, 1, c0 + LAT});
    tick(14);
    chk("multi_held_a", held_a, 1);
    chk("multi_seen_a", q_a.size(), 0);
    press_a[0][2] = 1'b0;
    press_a[3][2] = 1'b0;
    tick(12);
    chk("multi_rel_held_a", held_a, 0);
    // release bounce on column 0
    wait_col(0, 8'hfe, c0);
    press_a[1][0] = 1'b1;
    q_a.push_back(ev_t'{1'b0, 1, 0, c0 + LAT});
    tick(14);
    chk("relb_seen_a", q_a.size(), 0);
    press_a[1][0] = 1'b0;
    tick(2);
    press_a[1][0] = 1'b1;
    tick(2);
    press_a[1][0] = 1'b0;
    tick(1);
    chk("relb_held_e5", held_a, 1);
    tick(5);
    chk("relb_held_e10", held_a, 1);
    chk("relb_col_e10", cols_a, 4'b1110);
    tick(4);
    chk("relb_held_e14", held_a, 1);
    tick(1);
    chk("relb_done_held", held_a, 0);
    chk("relb_next_col", cols_a, 4'b1101);
    // asynchronous reset while debouncing a press
    wait_col(0, 8'hfb, c0);
    press_a[2][2] = 1'b1;
    tick(5);
    chk("pre_rst_row_a", row_a, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cols_a", cols_a, 4'b1110);
    chk("mid_rst_held_a", held_a, 0);
    chk("mid_rst_idx_a", {row_a, col_a}, 0);
    chk("mid_rst_cols_b", cols_b, 8'hfe);
    press_a[2][2] = 1'b0;
    tick(2);
    rst = 1'b0;
    // 8-column build: key on the last column
    wait_col(1, 8'h7f, c0);
    press_b[1][7] = 1'b1;
    q_b.push_back(ev_t'{1'b0, 1, 7, c0 + LAT});
    tick(14);
    chk("b_press_held", held_b, 1);
    chk("b_press_seen", q_b.size(), 0);
    press_b[1][7] = 1'b0;
    tick(12);
    chk("b_rel_held", held_b, 0);
    chk("b_rel_wrap_col", cols_b, 8'hfe);
    tick(5);
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
